// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: queues CPU note events in a FIFO and assigns each
// to a voice (matching/free voice first, round-robin steal when all are busy).
module voice_allocator #(
  parameter int unsigned NVOICES    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             addr,
  input  logic [31:0]            data_in,
  output logic [31:0]            data_out,
  input  logic                   wen,
  input  logic                   ren,
  output logic                   ready,
  output logic [7*NVOICES-1:0]   voice_note,
  output logic [NVOICES-1:0]     voice_gate,
  output logic                   busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned VW = $clog2(NVOICES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} state_t;

  logic              r_ready_q;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  state_t            r_state;
  logic              r_ev_on;
  logic [6:0]        r_ev_note;
  logic [VW-1:0]     r_idx;
  logic              r_match_found;
  logic              r_free_found;
  logic [VW-1:0]     r_free_idx;
  logic [VW-1:0]     r_steal_ptr;
  logic [6:0]        r_note [NVOICES];
  logic [NVOICES-1:0] r_gate;

  logic              w_wr;
  logic              w_rd;
  logic              w_ev_wr;
  logic              w_all_off;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_status;
  logic              w_unused;

  assign ready     = r_ready_q & (wen | ren);
  assign w_wr      = wen & ready;
  assign w_rd      = ren & ready;
  assign w_ev_wr   = w_wr && (addr == 4'd0);
  assign w_all_off = w_wr && (addr == 4'd2);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_ev_wr & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_status  = {r_overflow, 3'b0, 5'(r_count), 7'b0, 16'(r_gate)};
  assign busy      = (r_state != S_IDLE) | ~w_empty;
  assign voice_gate = r_gate;
  assign w_unused  = ^data_in[31:8];

  for (genvar g = 0; g < int'(NVOICES); g++) begin : g_note
    assign voice_note[7*g +: 7] = r_note[g];
  end

  // Event storage; no reset needed since occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_all_off) r_fifo[r_wr_ptr] <= data_in[7:0];
  end

  // Bus handshake, FIFO pointers, status register and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_q  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      data_out   <= '0;
    end else begin
      r_ready_q <= wen | ren;
      if (w_all_off) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_rd) data_out <= (addr == 4'd1) ? w_status : '0;
      // A drop on the same edge as a status read leaves the flag set.
      if (w_ev_wr && w_full)             r_overflow <= 1'b1;
      else if (w_rd && (addr == 4'd1))   r_overflow <= 1'b0;
    end
  end

  // Allocation FSM and voice outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ev_on       <= 1'b0;
      r_ev_note     <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_steal_ptr   <= '0;
      r_gate        <= '0;
      for (int i = 0; i < int'(NVOICES); i++) r_note[i] <= '0;
    end else if (w_all_off) begin
      r_gate  <= '0;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_ev_on, r_ev_note} <= r_fifo[r_rd_ptr];
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_idx         <= '0;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_gate[r_idx] && (r_note[r_idx] == r_ev_note)) r_match_found <= 1'b1;
          if (!r_gate[r_idx] && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          if (r_idx == VW'(NVOICES - 1)) r_state <= S_APPLY;
          else                           r_idx   <= r_idx + VW'(1);
        end
        S_APPLY: begin
          if (r_ev_on) begin
            if (r_match_found) begin
              r_gate <= r_gate;
            end else if (r_free_found) begin
              r_note[r_free_idx] <= r_ev_note;
              r_gate[r_free_idx] <= 1'b1;
            end else begin
              r_note[r_steal_ptr] <= r_ev_note;
              r_gate[r_steal_ptr] <= 1'b1;
              r_steal_ptr <= (r_steal_ptr == VW'(NVOICES - 1)) ? '0 : r_steal_ptr + VW'(1);
            end
          end else begin
            for (int i = 0; i < int'(NVOICES); i++)
              if (r_gate[i] && (r_note[i] == r_ev_note)) r_gate[i] <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
